fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM encoding, datapath widths and the branch target helper.
package fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int FIFO_W = 2 * INSTR_W;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetchState_t;

    // Word offset is sign-extended then scaled to bytes; wraps freely.
    function automatic logic [31:0] calcTarget(
        input logic [31:0] base,
        input logic [15:0] offset
    );
        logic [31:0] ext;
        ext = {{16{offset[15]}}, offset};
        return base + {ext[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {instr, pc} pairs between fetch and decode.
// Flush wins over push and pop; storage resets to zero.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [FIFO_W-1:0] wrData,
    output logic [FIFO_W-1:0] rdData,
    output logic [1:0]        count
);

    logic [FIFO_W-1:0] mem [2];
    logic              rdPtr;
    logic              wrPtr;

    assign rdData = mem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rdPtr  <= 1'b0;
            wrPtr  <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requester feeding
// a 2-entry FIFO, with branch redirect and stale-response dropping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               decode_ready,
    input  logic               redirect_valid,
    input  logic [15:0]        redirect_offset,
    input  logic [31:0]        redirect_base
);

    fetchState_t       state;
    fetchState_t       nextState;
    logic [31:0]       pc;
    logic [31:0]       reqPc;
    logic [31:0]       target;
    logic [1:0]        fifoCount;
    logic [1:0]        cntAfter;
    logic [FIFO_W-1:0] headData;
    logic              accept;
    logic              push;
    logic              pop;

    assign target = calcTarget(redirect_base, redirect_offset);

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    assign accept = imem_req && imem_ready && !redirect_valid;
    assign push   = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop    = instr_valid && decode_ready && !redirect_valid;

    // Occupancy after this edge; outstanding is zero whenever it is used.
    assign cntAfter = fifoCount + {1'b0, push} - {1'b0, pop};

    assign instr_valid = (fifoCount != 2'd0);
    assign instr       = headData[FIFO_W-1:INSTR_W];
    assign instr_pc    = headData[INSTR_W-1:0];

    fetch_fifo uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .wrData ({imem_rdata, reqPc}),
        .rdData (headData),
        .count  (fifoCount)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            reqPc <= '0;
        end else begin
            state <= nextState;
            if (redirect_valid) begin
                pc <= target;
            end else if (accept) begin
                pc    <= pc + PC_INC;
                reqPc <= pc;
            end
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (redirect_valid || cntAfter < 2'd2)
                    nextState = REQ;
            end
            REQ: begin
                if (accept)
                    nextState = WAIT;
            end
            WAIT: begin
                // A response landing with a redirect is simply discarded.
                if (imem_rvalid)
                    nextState = (redirect_valid || cntAfter < 2'd2) ? REQ : IDLE;
                else if (redirect_valid)
                    nextState = DROP;
            end
            DROP: begin
                if (imem_rvalid)
                    nextState = REQ;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects,
// address wrap and reset during an outstanding request.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;
    logic        redirect_valid;
    logic [15:0] redirect_offset;
    logic [31:0] redirect_base;

    int nChecks = 0;
    int nFails = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .decode_ready    (decode_ready),
        .redirect_valid  (redirect_valid),
        .redirect_offset (redirect_offset),
        .redirect_base   (redirect_base)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller leaves the DUT in REQ with imem_ready=1.
    task automatic fetchOne(input logic [31:0] data, input logic [31:0] expPc,
                            input string tag);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        checkVal({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        checkVal({tag, "_pc"}, instr_pc, expPc);
        checkVal({tag, "_instr"}, instr, data);
    endtask

    initial begin
        rst             = 1'b1;
        imem_ready      = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = '0;
        decode_ready    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_offset = '0;
        redirect_base   = '0;
        step();
        step();
        checkVal("rst_req", {31'd0, imem_req}, 32'd0);
        checkVal("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkVal("rst_instr", instr, 32'd0);
        checkVal("rst_pc", instr_pc, 32'd0);

        rst = 1'b0;
        step();
        checkVal("first_req", {31'd0, imem_req}, 32'd1);
        checkVal("first_addr", imem_addr, 32'h0);

        // Streaming with one-cycle memory latency
        imem_ready   = 1'b1;
        decode_ready = 1'b1;
        fetchOne(32'hA000_0000, 32'h0, "s0");
        checkVal("s0_next_addr", imem_addr, 32'h4);
        fetchOne(32'hA000_0004, 32'h4, "s1");
        fetchOne(32'hA000_0008, 32'h8, "s2");

        // Decode stalled: two entries buffered, requests stop
        decode_ready = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA000_000C;
        step();
        imem_rvalid = 1'b0;
        checkVal("full_req", {31'd0, imem_req}, 32'd0);
        checkVal("full_head", instr_pc, 32'h8);
        step();
        step();
        checkVal("full_req_hold", {31'd0, imem_req}, 32'd0);
        decode_ready = 1'b1;
        imem_ready   = 1'b0;
        step();
        decode_ready = 1'b0;
        checkVal("pop_head_pc", instr_pc, 32'hC);
        checkVal("pop_head_instr", instr, 32'hA000_000C);
        checkVal("pop_req", {31'd0, imem_req}, 32'd1);
        checkVal("pop_addr", imem_addr, 32'h10);

        // Memory stalls: request and FIFO remain stable
        for (int i = 0; i < 5; i++) begin
            step();
            checkVal("stall_addr", imem_addr, 32'h10);
            checkVal("stall_req", {31'd0, imem_req}, 32'd1);
        end
        checkVal("stall_head", instr_pc, 32'hC);

        // Redirect while awaiting response
        imem_ready = 1'b1;
        step();
        imem_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_base   = 32'h0000_0100;
        redirect_offset = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        checkVal("drop_flush", {31'd0, instr_valid}, 32'd0);
        checkVal("drop_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        checkVal("drop_discard", {31'd0, instr_valid}, 32'd0);
        checkVal("drop_req2", {31'd0, imem_req}, 32'd1);
        checkVal("drop_addr", imem_addr, 32'hF8);
        imem_ready = 1'b1;
        fetchOne(32'hB000_00F8, 32'hF8, "tgt");

        // Redirect in REQ withdraws even with imem_ready high
        redirect_valid  = 1'b1;
        redirect_base   = 32'hFFFF_FFF0;
        redirect_offset = 16'h0003;
        step();
        redirect_valid = 1'b0;
        checkVal("rq_req", {31'd0, imem_req}, 32'd1);
        checkVal("rq_addr", imem_addr, 32'hFFFF_FFFC);
        checkVal("rq_flush", {31'd0, instr_valid}, 32'd0);

        // Top-of-memory wrap
        fetchOne(32'hC000_0000, 32'hFFFF_FFFC, "wrap");
        checkVal("wrap_addr", imem_addr, 32'h0);

        // Fill to IDLE, then redirect from IDLE
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hC000_0004;
        step();
        imem_rvalid = 1'b0;
        checkVal("idle_req", {31'd0, imem_req}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_base   = 32'h0000_2000;
        redirect_offset = 16'h0010;
        step();
        redirect_valid = 1'b0;
        checkVal("idle_rd_req", {31'd0, imem_req}, 32'd1);
        checkVal("idle_rd_addr", imem_addr, 32'h2040);
        checkVal("idle_rd_flush", {31'd0, instr_valid}, 32'd0);

        // Reset with a request outstanding
        imem_ready = 1'b1;
        step();
        rst        = 1'b1;
        imem_ready = 1'b0;
        #1;
        checkVal("arst_req", {31'd0, imem_req}, 32'd0);
        step();
        rst = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hEEEE_EEEE;
        step();
        imem_rvalid = 1'b0;
        checkVal("arst_ignore", {31'd0, instr_valid}, 32'd0);
        checkVal("arst_addr", imem_addr, 32'h0);
        checkVal("arst_req2", {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        fetchOne(32'h1234_5678, 32'h0, "arst_first");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
